pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Control unit for the 16-bit fetch/decode pipeline: PC register, PC+2 adder, next-PC mux, instruction memory, IF/ID buffer.
- Sequences start-up fill, load-use stalls, taken-branch redirect/flush and halt by driving PC write-enable, next-PC mux select, IF/ID write/flush and the ID/EX bubble.
- Keeps saturating stall/flush event counters for debug.

Parameters:
- HALT_OPCODE, 4'hF, opcode value in IF/ID that halts fetch.
- FILL_CYCLES, 2, cycles spent in FILL after start before hazard checking begins (range 1..15).
- CNT_W, 16, width of event counters.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin fetching; sampled only in IDLE.
- id_opcode  in  4  opcode field of instruction currently in IF/ID.
- id_rs  in  4  source register 1 of IF/ID instruction.
- id_rt  in  4  source register 2 of IF/ID instruction.
- ex_mem_read  in  1  instruction in ID/EX is a load.
- ex_rd  in  4  destination register of ID/EX instruction.
- branch_taken  in  1  branch in ID resolved taken this cycle.
- pc_write  out  1  1 = PC loads next-PC mux output.
- pc_sel  out  1  next-PC mux select: 0 = PC+2, 1 = branch target.
- if_id_write  out  1  1 = IF/ID buffer captures PC+2/instruction.
- if_id_flush  out  1  1 = IF/ID buffer loads NOP.
- id_ex_bubble  out  1  1 = ID/EX receives a bubble (no-op controls).
- state  out  2  current FSM state encoding.
- stall_cnt  out  CNT_W  load-use stall cycles since reset, saturating.
- flush_cnt  out  CNT_W  branch flushes since reset, saturating.

Behaviour:
- Single clock `clk`; `rst` synchronous active-high. When rst=1 at an edge: state<=IDLE, fill counter<=0, stall_cnt<=0, flush_cnt<=0.
- While rst=1, outputs are combinationally forced to IDLE values, regardless of current state.
- State encoding: IDLE=0, FILL=1, RUN=2, HALT=3. Outputs are combinational from state and current inputs (Mealy), so hazard response is same-cycle.
- IDLE:
  - pc_write=0, pc_sel=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1.
  - start=1 -> FILL with fill counter loaded to FILL_CYCLES-1.
- FILL:
  - pc_write=1, pc_sel=0, if_id_write=1, if_id_flush=0, id_ex_bubble=1.
  - All hazard inputs are ignored. Fill counter decrements each cycle.
  - At counter=0 -> RUN, so FILL lasts exactly FILL_CYCLES cycles.
- RUN, priority halt > load-use > branch > normal:
  - Halt (id_opcode==HALT_OPCODE): pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0. Next state HALT.
  - Load-use (ex_mem_read=1, ex_rd!=0, and ex_rd==id_rs or ex_rd==id_rt): pc_write=0, if_id_write=0, id_ex_bubble=1, pc_sel=0. stall_cnt increments. Stay in RUN.
  - A load-use stall suppresses a simultaneous branch_taken; the branch takes effect in the following cycle, when it is re-presented.
  - Branch (branch_taken=1, no load-use): pc_write=1, pc_sel=1, if_id_write=1, if_id_flush=1, id_ex_bubble=0. flush_cnt increments.
  - Normal: pc_write=1, pc_sel=0, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- HALT:
  - Outputs equal IDLE values except if_id_flush=0, so the halt instruction is retained for debug.
  - start is ignored. Only rst exits HALT.
- Counters: +1 per qualifying cycle and hold at all-ones (no wrap). Both are cleared only by rst.
- Register 0 never causes a stall (ex_rd=0 means no writeback).

Test Plan:
- rst=1 for 2 cycles, then start=1 for 1 cycle with FILL_CYCLES=2 -> state 0,0,1,1,2; pc_write=0 in IDLE and 1 from the FILL entry cycle; id_ex_bubble=1 through both FILL cycles, 0 in RUN.
- RUN, ex_mem_read=1, ex_rd=3, id_rs=3 for 1 cycle -> that cycle pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle normal; stall_cnt=1. Repeat with ex_rd=0 -> no stall, stall_cnt stays 1.
- RUN, branch_taken=1 for 1 cycle -> pc_sel=1, pc_write=1, if_id_flush=1 that cycle only; flush_cnt=1.
- RUN, branch_taken=1 together with a load-use on id_rt=5/ex_rd=5 -> cycle 1: stall, pc_sel=0, flush_cnt=0; cycle 2 (load gone, branch held): branch redirect, flush_cnt=1, stall_cnt=1.
- RUN, id_opcode=4'hF with branch_taken=1 -> pc_write=0, id_ex_bubble=1, state->HALT; start=1 in HALT -> remains HALT; rst=1 -> IDLE, counters 0.
- Force stall_cnt near saturation (CNT_W=4 build) with 20 consecutive load-use cycles -> stall_cnt reads 4'hF and holds; assert rst mid-stall -> outputs immediately at IDLE values, next cycle state=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing control for the 16-bit fetch/decode pipeline: start-up fill,
// load-use stalls, taken-branch redirect/flush, halt, plus saturating debug counters.
module pipeline_hazard_ctrl #(
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter int unsigned FILL_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       id_opcode,
  input  logic [3:0]       id_rs,
  input  logic [3:0]       id_rt,
  input  logic             ex_mem_read,
  input  logic [3:0]       ex_rd,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned FILL_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [FILL_W-1:0] r_fill_cnt;
  logic [FILL_W-1:0] w_next_fill;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              w_halt;
  logic              w_load_use;
  logic              w_stall_inc;
  logic              w_flush_inc;

  // Hazard detection on the IF/ID instruction; register 0 never writes back.
  always_comb begin
    w_halt     = (id_opcode == HALT_OPCODE);
    w_load_use = ex_mem_read && (ex_rd != 4'd0) &&
                 ((ex_rd == id_rs) || (ex_rd == id_rt));
  end

  // Next-state and Mealy control outputs.
  always_comb begin
    w_next_state = r_state;
    w_next_fill  = r_fill_cnt;
    pc_write     = 1'b0;
    pc_sel       = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b1;
    id_ex_bubble = 1'b1;
    w_stall_inc  = 1'b0;
    w_flush_inc  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_FILL;
          w_next_fill  = FILL_W'(FILL_CYCLES - 1);
        end
      end
      S_FILL: begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        if (r_fill_cnt == '0) begin
          w_next_state = S_RUN;
        end else begin
          w_next_fill = r_fill_cnt - FILL_W'(1);
        end
      end
      S_RUN: begin
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (w_halt) begin
          id_ex_bubble = 1'b1;
          w_next_state = S_HALT;
        end else if (w_load_use) begin
          // A simultaneous branch is dropped here and re-presented next cycle.
          id_ex_bubble = 1'b1;
          w_stall_inc  = 1'b1;
        end else if (branch_taken) begin
          pc_write    = 1'b1;
          pc_sel      = 1'b1;
          if_id_write = 1'b1;
          if_id_flush = 1'b1;
          w_flush_inc = 1'b1;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
        end
      end
      S_HALT: begin
        // Keep the halt instruction visible in IF/ID.
        if_id_flush = 1'b0;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    if (rst) begin
      pc_write     = 1'b0;
      pc_sel       = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      w_stall_inc  = 1'b0;
      w_flush_inc  = 1'b0;
    end
  end

  // State and fill counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fill_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_fill_cnt <= w_next_fill;
    end
  end

  // Saturating debug counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed + randomized bench for pipeline_hazard_ctrl against a cycle-level
// behavioural model of the fill/run/halt rules (4-bit counters to reach saturation).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned FILL_N  = 2;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [3:0]       id_opcode;
  logic [3:0]       id_rs;
  logic [3:0]       id_rt;
  logic             ex_mem_read;
  logic [3:0]       ex_rd;
  logic             branch_taken;
  logic             pc_write;
  logic             pc_sel;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipeline_hazard_ctrl #(
    .HALT_OPCODE(4'hF),
    .FILL_CYCLES(FILL_N),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .id_opcode   (id_opcode),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .branch_taken(branch_taken),
    .pc_write    (pc_write),
    .pc_sel      (pc_sel),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .id_ex_bubble(id_ex_bubble),
    .state       (state),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 idle, 1 filling, 2 running, 3 halted.
  int m_phase     = 0;
  int m_fill_left = 0;
  int m_stalls    = 0;
  int m_flushes   = 0;

  function automatic bit hazard_load_use();
    return ex_mem_read && (ex_rd != 0) && ((ex_rd == id_rs) || (ex_rd == id_rt));
  endfunction

  // Expected {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble}.
  function automatic logic [4:0] expect_ctrl();
    if (rst)          return 5'b00011;
    if (m_phase == 0) return 5'b00011;
    if (m_phase == 1) return 5'b10101;
    if (m_phase == 3) return 5'b00001;
    if (id_opcode == 4'hF) return 5'b00001;
    if (hazard_load_use()) return 5'b00001;
    if (branch_taken)      return 5'b11110;
    return 5'b10100;
  endfunction

  task automatic check5(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check at the falling edge, then advance the model across the rising edge.
  task automatic cycle(input string tag);
    bit lu;
    @(negedge clk);
    check5({tag, ".ctrl"}, {pc_write, pc_sel, if_id_write, if_id_flush, id_ex_bubble}, expect_ctrl());
    check_val({tag, ".state"}, int'(state), m_phase);
    check_val({tag, ".stall_cnt"}, int'(stall_cnt), m_stalls);
    check_val({tag, ".flush_cnt"}, int'(flush_cnt), m_flushes);
    lu = hazard_load_use();
    if (rst) begin
      m_phase   = 0;
      m_stalls  = 0;
      m_flushes = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_fill_left = FILL_N; end
        1: begin
          m_fill_left--;
          if (m_fill_left == 0) m_phase = 2;
        end
        2: begin
          if (id_opcode == 4'hF) m_phase = 3;
          else if (lu) m_stalls = (m_stalls < CNT_MAX) ? m_stalls + 1 : CNT_MAX;
          else if (branch_taken) m_flushes = (m_flushes < CNT_MAX) ? m_flushes + 1 : CNT_MAX;
        end
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit st, input int op, input int rs, input int rt,
                        input bit mr, input int rd, input bit br);
    start        = st;
    id_opcode    = 4'(op);
    id_rs        = 4'(rs);
    id_rt        = 4'(rt);
    ex_mem_read  = mr;
    ex_rd        = 4'(rd);
    branch_taken = br;
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 1, 2, 0, 0, 0);
    cycle("rst0");
    cycle("rst1");
    rst = 1'b0;

    set_in(1, 0, 1, 2, 0, 0, 0);
    cycle("idle_start");
    set_in(0, 0, 1, 2, 0, 0, 0);
    cycle("fill0");
    cycle("fill1");
    cycle("run_normal");

    set_in(0, 0, 3, 7, 1, 3, 0);
    cycle("lu_rs");
    set_in(0, 0, 3, 7, 0, 3, 0);
    cycle("lu_after");
    set_in(0, 0, 0, 7, 1, 0, 0);
    cycle("lu_r0");
    set_in(0, 0, 1, 2, 0, 0, 0);
    cycle("lu_r0_after");

    set_in(0, 0, 1, 2, 0, 0, 1);
    cycle("branch");
    set_in(0, 0, 1, 2, 0, 0, 0);
    cycle("branch_after");

    set_in(0, 0, 1, 5, 1, 5, 1);
    cycle("br_lu_stall");
    set_in(0, 0, 1, 5, 0, 5, 1);
    cycle("br_lu_redirect");
    set_in(0, 0, 1, 2, 0, 0, 0);
    cycle("br_lu_after");

    set_in(0, 0, 3, 3, 1, 3, 0);
    for (int i = 0; i < 20; i++) cycle("sat_stall");
    check_val("stall_saturated", int'(stall_cnt), 15);
    rst = 1'b1;
    cycle("rst_mid_stall");
    rst = 1'b0;
    set_in(0, 0, 1, 2, 0, 0, 0);
    cycle("post_rst_idle");

    set_in(1, 0, 1, 2, 0, 0, 0);
    cycle("restart");
    set_in(0, 0, 1, 2, 0, 0, 0);
    cycle("refill0");
    cycle("refill1");
    set_in(0, 15, 1, 2, 0, 0, 1);
    cycle("halt_br");
    set_in(1, 15, 1, 2, 0, 0, 0);
    cycle("halt_start0");
    cycle("halt_start1");
    rst = 1'b1;
    cycle("halt_rst");
    rst = 1'b0;
    set_in(0, 0, 1, 2, 0, 0, 0);
    cycle("halt_rst_after");

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_in($urandom_range(0, 3) == 0,
             ($urandom_range(0, 19) == 0) ? 15 : int'($urandom_range(0, 14)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
             $urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
